// File: rtl/camera_reg_pkg.sv
// Shared constants and parameter helpers for the camera control/status register bank.
package camera_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Width of the word index once byte-offset bits are dropped from the address.
  function automatic int idx_w(input int addr_w, input int data_w);
    return addr_w - $clog2(data_w / 8);
  endfunction

  function automatic bit params_ok(input int data_w, input int num_regs,
                                   input int num_ro, input int addr_w);
    return ((data_w == 32) || (data_w == 64)) &&
           (num_regs >= 2) && (num_regs <= 64) &&
           (num_ro >= 0) && (num_ro < num_regs) &&
           (addr_w >= $clog2(num_regs) + $clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/camera_reg_bank.sv
// AXI4-Lite register bank: RW control words plus read-only status words,
// with byte-strobe merging, SLVERR on illegal accesses and per-register write pulses.
module camera_reg_bank
  import camera_reg_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS           = 8,
  parameter int NUM_RO             = 2,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                                                   s00_axi_aclk,
  input  logic                                                   s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                          s00_axi_awaddr,
  input  logic [2:0]                                             s00_axi_awprot,
  input  logic                                                   s00_axi_awvalid,
  output logic                                                   s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                          s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                        s00_axi_wstrb,
  input  logic                                                   s00_axi_wvalid,
  output logic                                                   s00_axi_wready,
  output logic [1:0]                                             s00_axi_bresp,
  output logic                                                   s00_axi_bvalid,
  input  logic                                                   s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                          s00_axi_araddr,
  input  logic [2:0]                                             s00_axi_arprot,
  input  logic                                                   s00_axi_arvalid,
  output logic                                                   s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                          s00_axi_rdata,
  output logic [1:0]                                             s00_axi_rresp,
  output logic                                                   s00_axi_rvalid,
  input  logic                                                   s00_axi_rready,
  output logic [(NUM_REGS-NUM_RO)*C_S_AXI_DATA_WIDTH-1:0]        ctrl_o,
  output logic [NUM_REGS-NUM_RO-1:0]                             wr_pulse_o,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*C_S_AXI_DATA_WIDTH-1:0] status_i
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int AW     = C_S_AXI_ADDR_WIDTH;
  localparam int LSB    = $clog2(DW / 8);
  localparam int IW     = idx_w(AW, DW);
  localparam int NUM_RW = NUM_REGS - NUM_RO;

  if (!params_ok(DW, NUM_REGS, NUM_RO, AW)) begin : g_param_err
    $error("camera_reg_bank: illegal parameter combination");
  end

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_word,
                                                input logic [DW-1:0] new_word,
                                                input logic [DW/8-1:0] strb);
    logic [DW-1:0] res;
    res = old_word;
    for (int b = 0; b < DW / 8; b++)
      if (strb[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    return res;
  endfunction

  logic [DW-1:0]     regs [NUM_RW];
  logic              aw_full, w_full;
  logic [IW-1:0]     aw_idx;
  logic [DW-1:0]     w_data;
  logic [DW/8-1:0]   w_strb;
  logic [NUM_RW-1:0] wr_pulse;
  logic              wr_legal;
  logic [IW-1:0]     ar_idx;
  logic [DW-1:0]     rd_word;
  logic              rd_ok;
  logic              unused_sigs;

  assign unused_sigs = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[LSB-1:0], s00_axi_araddr[LSB-1:0]};

  assign s00_axi_awready = !aw_full && !s00_axi_bvalid;
  assign s00_axi_wready  = !w_full && !s00_axi_bvalid;
  assign s00_axi_arready = !s00_axi_rvalid;
  assign wr_pulse_o      = wr_pulse;
  // Index beyond the RW block covers both the RO status words and unmapped space.
  assign wr_legal        = (32'(aw_idx) < NUM_RW);

  for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl
    assign ctrl_o[g*DW +: DW] = regs[g];
  end

  // Write path: independent AW/W holding registers, commit once both are held
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      aw_full        <= 1'b0;
      w_full         <= 1'b0;
      aw_idx         <= '0;
      w_data         <= '0;
      w_strb         <= '0;
      s00_axi_bvalid <= 1'b0;
      s00_axi_bresp  <= RESP_OKAY;
      wr_pulse       <= '0;
      for (int r = 0; r < NUM_RW; r++) regs[r] <= '0;
    end else begin
      wr_pulse <= '0;
      if (s00_axi_awvalid && s00_axi_awready) begin
        aw_full <= 1'b1;
        aw_idx  <= s00_axi_awaddr[AW-1:LSB];
      end
      if (s00_axi_wvalid && s00_axi_wready) begin
        w_full <= 1'b1;
        w_data <= s00_axi_wdata;
        w_strb <= s00_axi_wstrb;
      end
      if (aw_full && w_full) begin
        aw_full        <= 1'b0;
        w_full         <= 1'b0;
        s00_axi_bvalid <= 1'b1;
        s00_axi_bresp  <= wr_legal ? RESP_OKAY : RESP_SLVERR;
        for (int r = 0; r < NUM_RW; r++) begin
          if (wr_legal && (aw_idx == IW'(r))) begin
            regs[r]     <= merge_bytes(regs[r], w_data, w_strb);
            wr_pulse[r] <= 1'b1;
          end
        end
      end else if (s00_axi_bvalid && s00_axi_bready) begin
        s00_axi_bvalid <= 1'b0;
      end
    end
  end

  assign ar_idx = s00_axi_araddr[AW-1:LSB];
  assign rd_ok  = (32'(ar_idx) < NUM_REGS);

  always_comb begin
    rd_word = '0;
    for (int r = 0; r < NUM_RW; r++)
      if (ar_idx == IW'(r)) rd_word = regs[r];
    for (int s = 0; s < NUM_RO; s++)
      if (ar_idx == IW'(NUM_RW + s)) rd_word = status_i[s*DW +: DW];
  end

  // Read path: registers sample pre-commit contents, so a same-edge write is not visible
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      s00_axi_rvalid <= 1'b0;
      s00_axi_rdata  <= '0;
      s00_axi_rresp  <= RESP_OKAY;
    end else if (s00_axi_arvalid && s00_axi_arready) begin
      s00_axi_rvalid <= 1'b1;
      s00_axi_rdata  <= rd_word;
      s00_axi_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (s00_axi_rvalid && s00_axi_rready) begin
      s00_axi_rvalid <= 1'b0;
    end
  end

endmodule
